// File: rtl/fir_ctrl_sched.sv
// FIR control scheduler: 40-tap coefficient store with load FSM and
// per-sample enable sequencing for the 4-bank multiply/add/accumulate path.
// Ports: iClk_12M/iRst (sync, active-high); iCoeffUpdate/iCoeffWrEn/
//   iCoeffAddr/iCoeffData load taps; iCoeffRdAddr/oCoeffRdData readback;
//   oCoeffFlat all taps; oEnMul/oEnAdd/oEnAcc/oEnSample_300k enables;
//   oRun in RUN; oCoeffErr sticky load error.
// Option: define FIR_CTRL_READBACK_EN for registered tap readback.
module fir_ctrl_sched #(
  parameter int SAMPLE_DIV = 40
) (
  input  logic         iClk_12M,
  input  logic         iRst,
  input  logic         iCoeffUpdate,
  input  logic         iCoeffWrEn,
  input  logic [5:0]   iCoeffAddr,
  input  logic [15:0]  iCoeffData,
  input  logic [5:0]   iCoeffRdAddr,
  output logic [15:0]  oCoeffRdData,
  output logic [639:0] oCoeffFlat,
  output logic         oEnSample_300k,
  output logic [3:0]   oEnMul,
  output logic         oEnAdd,
  output logic         oEnAcc,
  output logic         oRun,
  output logic         oCoeffErr
);

  localparam int NTAP = 40;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(SAMPLE_DIV - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [39:0] mask;
  logic [39:0] mask_nxt;
  logic [15:0] tap [NTAP];
  logic        err;
  logic        in_load;
  logic        in_run;
  logic        wr_ok;
  logic        wr_bad;
  logic        load_ok;

  assign in_load = (state == S_LOAD);
  assign in_run  = (state == S_RUN);
  assign wr_ok   = in_load & iCoeffWrEn & (iCoeffAddr < 6'd40);
  assign wr_bad  = in_load & iCoeffWrEn & (iCoeffAddr >= 6'd40);

  // Mask as it will be after this edge, so an exit-cycle write counts.
  always_comb begin
    mask_nxt = mask;
    for (int i = 0; i < NTAP; i++) begin
      if (wr_ok && iCoeffAddr == 6'(i)) mask_nxt[i] = 1'b1;
    end
  end

  assign load_ok = (&mask_nxt) & ~err & ~wr_bad;

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state <= S_IDLE;
      cnt   <= '0;
      mask  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iCoeffUpdate) begin
            state <= S_LOAD;
            mask  <= '0;
            err   <= 1'b0;
          end
        end
        S_LOAD: begin
          mask <= mask_nxt;
          if (wr_bad) err <= 1'b1;
          if (!iCoeffUpdate) begin
            if (load_ok) begin
              state <= S_RUN;
              cnt   <= '0;
            end else begin
              state <= S_IDLE;
              err   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (iCoeffUpdate) begin
            state <= S_LOAD;
            cnt   <= '0;
            mask  <= '0;
            err   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      for (int i = 0; i < NTAP; i++) tap[i] <= '0;
    end else begin
      for (int i = 0; i < NTAP; i++) begin
        if (wr_ok && iCoeffAddr == 6'(i)) tap[i] <= iCoeffData;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NTAP; i++) oCoeffFlat[16*i +: 16] = tap[i];
  end

  assign oRun           = in_run;
  assign oCoeffErr      = err;
  assign oEnMul[0]      = in_run & (cnt == 8'd0);
  assign oEnMul[1]      = in_run & (cnt == 8'd1);
  assign oEnMul[2]      = in_run & (cnt == 8'd2);
  assign oEnMul[3]      = in_run & (cnt == 8'd3);
  assign oEnAdd         = in_run & (cnt == 8'd4);
  assign oEnAcc         = in_run & (cnt == 8'd5);
  assign oEnSample_300k = in_run & (cnt == CNT_LAST);

`ifdef FIR_CTRL_READBACK_EN
  logic [15:0] rd_sel;

  // Out-of-range addresses fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (iCoeffRdAddr == 6'(i)) rd_sel = tap[i];
    end
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) oCoeffRdData <= '0;
    else      oCoeffRdData <= rd_sel;
  end
`else
  logic unused_rd;
  assign unused_rd    = ^iCoeffRdAddr;
  assign oCoeffRdData = '0;
`endif

endmodule

// File: tb/tb_fir_ctrl_sched.sv
// Directed self-checking bench for fir_ctrl_sched (SAMPLE_DIV = 40).
// Drives load/run/error/reset scenarios and compares against hand values.
module tb_fir_ctrl_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         upd;
  logic         wren;
  logic [5:0]   addr;
  logic [15:0]  data;
  logic [5:0]   rd_addr;
  logic [15:0]  rd_data;
  logic [639:0] flat;
  logic         en_smp;
  logic [3:0]   en_mul;
  logic         en_add;
  logic         en_acc;
  logic         run;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  fir_ctrl_sched #(.SAMPLE_DIV(40)) dut (
    .iClk_12M       (clk),
    .iRst           (rst),
    .iCoeffUpdate   (upd),
    .iCoeffWrEn     (wren),
    .iCoeffAddr     (addr),
    .iCoeffData     (data),
    .iCoeffRdAddr   (rd_addr),
    .oCoeffRdData   (rd_data),
    .oCoeffFlat     (flat),
    .oEnSample_300k (en_smp),
    .oEnMul         (en_mul),
    .oEnAdd         (en_add),
    .oEnAcc         (en_acc),
    .oRun           (run),
    .oCoeffErr      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [639:0] got,
                       input logic [639:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] en_vec();
    return {en_smp, en_acc, en_add, en_mul};
  endfunction

  function automatic logic [6:0] en_exp(input int c);
    logic [6:0] v;
    v = '0;
    if (c < 4)   v[c] = 1'b1;
    if (c == 4)  v[4] = 1'b1;
    if (c == 5)  v[5] = 1'b1;
    if (c == 39) v[6] = 1'b1;
    return v;
  endfunction

  // Writes taps 0..n-1 with base+i while in LOAD; when drop is set,
  // iCoeffUpdate falls together with the final write.
  task automatic write_taps(input int n, input int base, input bit drop);
    for (int i = 0; i < n; i++) begin
      wren = 1'b1;
      addr = 6'(i);
      data = 16'(base + i);
      upd  = (drop && i == n - 1) ? 1'b0 : 1'b1;
      step();
    end
    wren = 1'b0;
    if (!drop) begin
      upd = 1'b0;
      step();
    end
  endtask

  initial begin
    logic [15:0] rb_exp;
    logic [639:0] flat_run;
    rst = 1'b1; upd = 1'b0; wren = 1'b0;
    addr = '0; data = '0; rd_addr = 6'd39;
    step(2);
    check("rst_run", run, 0);
    check("rst_flat", flat, 0);
    check("rst_en", en_vec(), 0);
    check("rst_err", err, 0);
    check("rst_rd", rd_data, 0);
    rst = 1'b0;
    step();

    // Full load, final write in the exit cycle.
    upd = 1'b1;
    step();
    check("load_run", run, 0);
    write_taps(40, 100, 1'b1);
    check("load_ok_run", run, 1);
    check("load_ok_err", err, 0);
    check("flat_t0", flat[15:0], 100);
    check("flat_t39", flat[639:624], 139);
    flat_run = flat;

    // Enable sequence across three sample periods.
    for (int c = 0; c < 120; c++) begin
      check($sformatf("en_c%0d", c), en_vec(), en_exp(c % 40));
      step();
    end
    check("flat_stable", flat, flat_run);
`ifdef FIR_CTRL_READBACK_EN
    rb_exp = 16'd139;
`else
    rb_exp = 16'd0;
`endif
    check("rd_t39", rd_data, rb_exp);

    // Reload request at counter 3.
    step(3);
    check("c3_mul", en_mul, 4'b1000);
    upd = 1'b1;
    step();
    check("reload_en", en_vec(), 0);
    check("reload_run", run, 0);

    // Incomplete load (taps 0..38).
    write_taps(39, 200, 1'b0);
    check("part_err", err, 1);
    check("part_run", run, 0);
    check("part_en", en_vec(), 0);
    check("part_t0", flat[15:0], 200);

    // Writes outside LOAD are ignored.
    wren = 1'b1; addr = 6'd0; data = 16'h7777;
    step();
    wren = 1'b0;
    check("idle_wr_t0", flat[15:0], 200);
    check("idle_wr_err", err, 1);

    // Bad address then a complete load still fails.
    upd = 1'b1;
    step();
    check("entry_err_clr", err, 0);
    wren = 1'b1; addr = 6'd45; data = 16'hdead;
    step();
    check("bad_addr_err", err, 1);
    write_taps(40, 300, 1'b1);
    check("bad_exit_err", err, 1);
    check("bad_exit_run", run, 0);
    check("bad_t39", flat[639:624], 339);

    // Clean reload, counter restarts at 0.
    upd = 1'b1;
    step();
    check("reent_err_clr", err, 0);
    write_taps(40, 100, 1'b1);
    check("rerun_run", run, 1);
    check("rerun_c0", en_vec(), en_exp(0));
    step(20);
    check("c20_en", en_vec(), en_exp(20));

    // Reset mid sample period.
    rd_addr = 6'd0;
    rst = 1'b1;
    step();
    check("mrst_run", run, 0);
    check("mrst_en", en_vec(), 0);
    check("mrst_flat", flat, 0);
    check("mrst_err", err, 0);
    rst = 1'b0;
    step();
    check("mrst_rd_t0", rd_data, 0);
    check("mrst_idle_run", run, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_ctrl_sched.md
FIR_CTRL_SCHED -- requirements
Module: fir_ctrl_sched

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 40: clock cycles per sample period (12 MHz / 40 = 300 kHz), legal range 8..255.
REQ-002 The block SHALL have port iClk_12M, input, 1 bit: sole clock; all logic on rising edge.
REQ-003 The block SHALL have port iRst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port iCoeffUpdate, input, 1 bit: level request to enter/stay in coefficient load mode.
REQ-005 The block SHALL have port iCoeffWrEn, input, 1 bit: coefficient write strobe.
REQ-006 The block SHALL have port iCoeffAddr, input, 6 bits: write tap index, 0..39 legal.
REQ-007 The block SHALL have port iCoeffData, input, 16 bits: signed coefficient.
REQ-008 The block SHALL have port iCoeffRdAddr, input, 6 bits: readback tap index.
REQ-009 The block SHALL have port oCoeffRdData, output, 16 bits: readback data.
REQ-010 The block SHALL have port oCoeffFlat, output, 640 bits: tap n at bits [16n+15:16n]; bank b = taps 10b..10b+9.
REQ-011 The block SHALL have port oEnSample_300k, output, 1 bit: sample-enable pulse.
REQ-012 The block SHALL have port oEnMul, output, 4 bits: per-bank multiply enables.
REQ-013 The block SHALL have ports oEnAdd and oEnAcc, outputs, 1 bit each: adder and accumulate enables.
REQ-014 The block SHALL have port oRun, output, 1 bit: high in RUN.
REQ-015 The block SHALL have port oCoeffErr, output, 1 bit: sticky load-error flag.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-017 IDLE SHALL go to LOAD when iCoeffUpdate=1.
REQ-018 RUN SHALL go to LOAD when iCoeffUpdate=1, with the sample counter cleared and all enables low from the next cycle.
REQ-019 On every entry to LOAD, the 40-bit written-mask and oCoeffErr SHALL clear.
REQ-020 In LOAD, iCoeffWrEn=1 with iCoeffAddr<40 SHALL write iCoeffData to tap[iCoeffAddr] and set its mask bit at the next edge; rewrites are allowed, last value wins.
REQ-021 In LOAD, iCoeffWrEn=1 with iCoeffAddr>=40 SHALL write nothing and set oCoeffErr.
REQ-022 LOAD SHALL exit when iCoeffUpdate=0: to RUN if all 40 mask bits are set (a write in the exit cycle counts) and oCoeffErr=0; otherwise to IDLE with oCoeffErr=1.
REQ-023 Writes outside LOAD SHALL be ignored and leave taps and oCoeffErr unchanged.
REQ-024 In RUN, the counter SHALL count 0..SAMPLE_DIV-1 and wrap to 0; the first RUN cycle has counter=0.
REQ-025 All enable outputs SHALL be decoded from the registered counter and be 0 outside RUN.
REQ-026 In RUN, oEnMul[b] SHALL be 1 exactly when counter=b, for b=0..3.
REQ-027 In RUN, oEnAdd SHALL be 1 when counter=4, and oEnAcc SHALL be 1 when counter=5.
REQ-028 In RUN, oEnSample_300k SHALL be 1 when counter=SAMPLE_DIV-1, giving one pulse every SAMPLE_DIV cycles.
REQ-029 oCoeffFlat SHALL reflect the tap registers directly and be stable throughout RUN.

Reset
REQ-030 While iRst=1 at a clock edge, the FSM SHALL go to IDLE; counter, mask, all taps, oCoeffRdData, oCoeffErr, oRun and all enables SHALL be 0.
REQ-031 Reset SHALL take priority over every other input, including mid-LOAD and mid-sample-period.

Configuration
REQ-032 With macro FIR_CTRL_READBACK_EN defined, oCoeffRdData SHALL be registered tap[iCoeffRdAddr] with 1-cycle latency in any state, and 0 for addresses >=40.
REQ-033 Without FIR_CTRL_READBACK_EN, oCoeffRdData SHALL be constant 0 and iCoeffRdAddr unused.

Verification
REQ-034 Reset, raise iCoeffUpdate, write taps 0..39 with value 100+n, drop iCoeffUpdate -> oRun=1 next cycle, oCoeffFlat[15:0]=100, oCoeffFlat[639:624]=139.
REQ-035 In RUN with SAMPLE_DIV=40 -> oEnMul=0001/0010/0100/1000 at counter 0..3, oEnAdd at 4, oEnAcc at 5, oEnSample_300k at 39, 79, 119 cycles after RUN entry.
REQ-036 Load only taps 0..38 and drop iCoeffUpdate -> state IDLE, oCoeffErr=1, oRun=0, all enables 0.
REQ-037 Write addr 45 during LOAD, then complete all 40 taps -> exit to IDLE with oCoeffErr=1; a new LOAD entry clears oCoeffErr.
REQ-038 Assert iRst at counter=20 in RUN -> next cycle all outputs 0 and tap 0 reads 0 (with FIR_CTRL_READBACK_EN, iCoeffRdAddr=0 -> oCoeffRdData=0 one cycle later).
REQ-039 iCoeffUpdate=1 at counter=3 in RUN -> oEnMul[3] does not assert on the following cycle; after reload, the counter restarts at 0.
